// File: rtl/vga_timing_pkg.sv
// Package for the VGA result display.
// Holds the default 640x480@60 timing constants, the derived totals and
// counter widths, the rgb_t pixel type, and a width helper.
package vga_timing_pkg;

  localparam int CLK_DIV_DEF  = 4;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int BORDER_DEF   = 8;
  localparam int COLOR_W_DEF  = 4;

  localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int H_CNT_W     = $clog2(H_TOTAL_DEF);
  localparam int V_CNT_W     = $clog2(V_TOTAL_DEF);

  typedef struct packed {
    logic [COLOR_W_DEF-1:0] r;
    logic [COLOR_W_DEF-1:0] g;
    logic [COLOR_W_DEF-1:0] b;
  } rgb_t;

  // Counter width for a modulus; never below one bit so CLK_DIV = 1 still
  // yields a legal (constant-zero) divider register.
  function automatic int cnt_width(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-clock divider and raster counters.
// Ports: clk/rst_n; h_cnt, v_cnt raster position; pix_tick one clock per
// pixel; frame_wrap marks the tick that moves the counters to (0,0).
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int H_TOTAL = H_TOTAL_DEF,
  parameter int V_TOTAL = V_TOTAL_DEF,
  parameter int HW      = cnt_width(H_TOTAL),
  parameter int VW      = cnt_width(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          pix_tick,
  output logic          frame_wrap
);

  localparam int DW = cnt_width(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);

  logic [DW-1:0] div_cnt;
  logic          h_wrap;
  logic          v_wrap;

  // With CLK_DIV = 1, DIV_LAST is 0, so pix_tick is constantly high and
  // div_cnt is reloaded with 0 every clock.
  assign pix_tick   = (div_cnt == DIV_LAST);
  assign h_wrap     = (h_cnt == H_LAST);
  assign v_wrap     = (v_cnt == V_LAST);
  assign frame_wrap = pix_tick && h_wrap && v_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else begin
      div_cnt <= pix_tick ? '0 : div_cnt + DW'(1);
      if (pix_tick) begin
        h_cnt <= h_wrap ? '0 : h_cnt + HW'(1);
        if (h_wrap) begin
          v_cnt <= v_wrap ? '0 : v_cnt + VW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/vga_result_display.sv
// VGA output stage: solid green (flag 1) or red (flag 0) with a white border.
// Ports: s_axi_aclk/s_axi_aresetn; result_in flag; registered vga_r/g/b,
// active-low vga_hs/vga_vs, frame_start pulse and active (visible) flag.
module vga_result_display
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = CLK_DIV_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int BORDER   = BORDER_DEF,
  parameter int COLOR_W  = COLOR_W_DEF
) (
  input  logic               s_axi_aclk,
  input  logic               s_axi_aresetn,
  input  logic               result_in,
  output logic [COLOR_W-1:0] vga_r,
  output logic [COLOR_W-1:0] vga_g,
  output logic [COLOR_W-1:0] vga_b,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic               frame_start,
  output logic               active
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = cnt_width(H_TOTAL);
  localparam int VW      = cnt_width(V_TOTAL);

  localparam logic [HW-1:0] H_VIS_END  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_BRD_LO   = HW'(BORDER);
  localparam logic [HW-1:0] H_BRD_HI   = HW'(H_ACTIVE - BORDER);
  localparam logic [HW-1:0] HS_BEGIN   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_VIS_END  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_BRD_LO   = VW'(BORDER);
  localparam logic [VW-1:0] V_BRD_HI   = VW'(V_ACTIVE - BORDER);
  localparam logic [VW-1:0] VS_BEGIN   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [COLOR_W-1:0] C_MAX = {COLOR_W{1'b1}};

  logic [HW-1:0]      h_cnt;
  logic [VW-1:0]      v_cnt;
  logic               pix_tick;
  logic               frame_wrap;
  logic               flag_q;
  logic               start_pend;

  logic               vis;
  logic               on_border;
  logic               hs_n;
  logic               vs_n;
  logic [COLOR_W-1:0] r_d;
  logic [COLOR_W-1:0] g_d;
  logic [COLOR_W-1:0] b_d;

  vga_timing_gen #(
    .CLK_DIV (CLK_DIV),
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .HW      (HW),
    .VW      (VW)
  ) u_timing (
    .clk        (s_axi_aclk),
    .rst_n      (s_axi_aresetn),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .pix_tick   (pix_tick),
    .frame_wrap (frame_wrap)
  );

  always_comb begin
    vis       = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
    hs_n      = !((h_cnt >= HS_BEGIN) && (h_cnt < HS_END));
    vs_n      = !((v_cnt >= VS_BEGIN) && (v_cnt < VS_END));
    on_border = vis && ((h_cnt < H_BRD_LO) || (h_cnt >= H_BRD_HI) ||
                        (v_cnt < V_BRD_LO) || (v_cnt >= V_BRD_HI));
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (on_border) begin
      r_d = C_MAX;
      g_d = C_MAX;
      b_d = C_MAX;
    end else if (vis) begin
      r_d = flag_q ? '0 : C_MAX;
      g_d = flag_q ? C_MAX : '0;
    end
  end

  // The flag is latched on the same tick that moves the counters to (0,0),
  // so the whole frame, including pixel (0,0), uses a single value.
  // start_pend remembers that the counters have just arrived at (0,0); it
  // comes out of reset set so the very first output clock is flagged too.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      flag_q      <= 1'b0;
      start_pend  <= 1'b1;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      active      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      if (frame_wrap) begin
        flag_q <= result_in;
      end
      start_pend  <= frame_wrap;
      vga_r       <= r_d;
      vga_g       <= g_d;
      vga_b       <= b_d;
      vga_hs      <= hs_n;
      vga_vs      <= vs_n;
      active      <= vis;
      frame_start <= start_pend && (h_cnt == '0) && (v_cnt == '0);
    end
  end

endmodule

// File: tb/tb_vga_result_display.sv
// Self-checking bench for vga_result_display on a shrunken raster.
// A clock-count reference model predicts every output on every clock.
module tb_vga_result_display;
  import vga_timing_pkg::*;

  localparam int CD  = 2;
  localparam int HA  = 40, HFP = 4, HSY = 6, HBP = 6;
  localparam int VA  = 30, VFP = 2, VSY = 2, VBP = 3;
  localparam int BRD = 4;
  localparam int HT  = HA + HFP + HSY + HBP;
  localparam int VT  = VA + VFP + VSY + VBP;
  localparam int FRAME_PIX  = HT * VT;
  localparam int FRAME_CLKS = FRAME_PIX * CD;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       result_in;
  logic [3:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, frame_start, active;

  int   checks   = 0;
  int   failures = 0;
  int   t;            // clock edges since reset release
  logic flags[$];     // flag in force for each frame since reset release

  always #5 clk = ~clk;

  vga_result_display #(
    .CLK_DIV (CD),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .BORDER  (BRD),
    .COLOR_W (4)
  ) dut (
    .s_axi_aclk   (clk),
    .s_axi_aresetn(rst_n),
    .result_in    (result_in),
    .vga_r        (vga_r),
    .vga_g        (vga_g),
    .vga_b        (vga_b),
    .vga_hs       (vga_hs),
    .vga_vs       (vga_vs),
    .frame_start  (frame_start),
    .active       (active)
  );

  function automatic logic [15:0] observed();
    return {vga_r, vga_g, vga_b, vga_hs, vga_vs, active, frame_start};
  endfunction

  // Output clock tt shows pixel number (tt-1)/CD of the continuous scan.
  function automatic logic [15:0] expected_at(input int tt);
    int   p, h, v, f;
    logic vis, brd, hs, vs, fs;
    rgb_t c;
    p   = (tt - 1) / CD;
    h   = p % HT;
    v   = (p / HT) % VT;
    f   = p / FRAME_PIX;
    vis = (h < HA) && (v < VA);
    brd = vis && (h < BRD || h >= HA - BRD || v < BRD || v >= VA - BRD);
    hs  = !(h >= HA + HFP && h < HA + HFP + HSY);
    vs  = !(v >= VA + VFP && v < VA + VFP + VSY);
    fs  = ((tt - 1) % FRAME_CLKS) == 0;
    if (!vis)         c = '{r: 4'h0, g: 4'h0, b: 4'h0};
    else if (brd)     c = '{r: 4'hF, g: 4'hF, b: 4'hF};
    else if (flags[f]) c = '{r: 4'h0, g: 4'hF, b: 4'h0};
    else              c = '{r: 4'hF, g: 4'h0, b: 4'h0};
    return {c, hs, vs, vis, fs};
  endfunction

  // One clock: the edge that lands on a frame boundary captures result_in
  // as the flag of the next frame; outputs are checked on the falling edge.
  task automatic step();
    logic [15:0] exp_v;
    @(posedge clk);
    t++;
    if (t % FRAME_CLKS == 0) flags.push_back(result_in);
    @(negedge clk);
    exp_v = expected_at(t);
    checks++;
    assert (observed() === exp_v) else begin
      failures++;
      $error("FAIL pixel t=%0d observed=%h expected=%h", t, observed(), exp_v);
    end
  endtask

  task automatic check_reset(input string tag);
    checks++;
    assert (observed() === 16'h000C) else begin
      failures++;
      $error("FAIL %s observed=%h expected=000c", tag, observed());
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    result_in = 1'b0;
    t         = 0;
    flags     = {1'b0};

    repeat (10) begin
      @(negedge clk);
      check_reset("reset_hold");
    end
    rst_n = 1'b1;

    // Frame 0 red; result_in goes high just before the first boundary and
    // drops at line 10 of the green frame 1, so frame 2 is red.
    for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
      step();
      result_in = (t >= FRAME_CLKS - 100) && (t < FRAME_CLKS + 10 * HT * CD);
    end
    // Random mid-frame flips; only the boundary value may matter.
    for (int i = 0; i < 3 * FRAME_CLKS; i++) begin
      step();
      if ($urandom_range(0, 299) == 0) result_in = ~result_in;
    end
    // Park mid-frame, then reset asynchronously between clock edges.
    for (int i = 0; i < 21 * HT * CD + 17; i++) begin
      step();
    end
    #2 rst_n = 1'b0;
    #1 check_reset("async_reset");
    repeat (4) begin
      @(negedge clk);
      check_reset("reset_hold2");
    end

    // After release frame 0 must be red even though result_in is high.
    t         = 0;
    flags     = {1'b0};
    result_in = 1'b1;
    rst_n     = 1'b1;
    for (int i = 0; i < FRAME_CLKS + 200; i++) begin
      step();
    end
    for (int i = 0; i < FRAME_CLKS; i++) begin
      step();
      if ($urandom_range(0, 299) == 0) result_in = ~result_in;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_result_display.md
# vga_result_display

Video output stage of the pitch-training display path. It consumes the 1-bit pitch-result flag held by the AXI-lite result register and drives a 640x480@60 VGA port. While the flag is 1 the screen is solid green; while it is 0 the screen is solid red. A white border frames both. The flag is sampled once per frame so the picture never tears.

## Interface
- CLK_DIV, 4: system clocks per pixel. 100 MHz / 4 gives a 25 MHz pixel rate. Must be at least 1.
- H_ACTIVE, 640; H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal timing, in pixels.
- V_ACTIVE, 480; V_FP, 10; V_SYNC, 2; V_BP, 33: vertical timing, in lines.
- BORDER, 8: border width in pixels and lines.
- COLOR_W, 4: bits per colour channel.
- s_axi_aclk  in  1  the single clock, shared with the AXI-lite register block.
- s_axi_aresetn  in  1  reset; one clock, asynchronous, active-low.
- result_in  in  1  pitch-result flag (1 = correct), level signal, synchronous to s_axi_aclk.
- vga_r, vga_g, vga_b  out  COLOR_W each  pixel colour.
- vga_hs, vga_vs  out  1 each  syncs, active-low.
- frame_start  out  1  one-clock pulse when pixel (0,0) first appears on the outputs.
- active  out  1  high while the outputs carry a visible pixel.

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800. V_TOTAL = 525.
- div_cnt counts 0..CLK_DIV-1 and wraps. pix_tick is high when div_cnt = CLK_DIV-1.
- h_cnt advances only on pix_tick. It wraps from H_TOTAL-1 to 0.
- v_cnt advances on a pix_tick where h_cnt wraps. It wraps from V_TOTAL-1 to 0.
- The two counters are 10 bits each (clog2 of the totals).
- flag_q loads result_in on the pix_tick where the counters move to (0,0). flag_q holds for the whole frame; mid-frame changes on result_in are ignored until the next frame.
- Per-pixel decode (combinational from h_cnt, v_cnt, flag_q):
  - vis = (h < H_ACTIVE) && (v < V_ACTIVE).
  - hs_n low when H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC, i.e. h in 656..751.
  - vs_n low when v in 490..491.
  - edge = vis && (h < BORDER || h ≥ H_ACTIVE-BORDER || v < BORDER || v ≥ V_ACTIVE-BORDER).
  - colour: edge → all channels all-ones; vis && !edge → flag_q ? (0, max, 0) : (max, 0, 0); !vis → all zero.
- All outputs are registered from this decode. frame_start_r = (h_cnt == 0 && v_cnt == 0 && the counters changed on the previous clock), or the first clock after reset.

## Timing
- Reset values: div_cnt = h_cnt = v_cnt = 0, flag_q = 0, vga_r/g/b = 0, vga_hs = vga_vs = 1, active = 0, frame_start = 0.
- Latency: the outputs for pixel (h,v) are valid 1 clock after the counters take (h,v). They are held for CLK_DIV clocks.
- Period: line = H_TOTAL*CLK_DIV = 3200 clocks. Frame = 525*3200 = 1,680,000 clocks. Hsync low 384 clocks. Vsync low 2 lines = 6400 clocks.
- First frame after reset: counters start at (0,0) with flag_q = 0, so the first frame is red/white. On the first clock after release, the outputs show pixel (0,0) and frame_start pulses.
- Reset asserted mid-frame: all state and outputs go to their reset values immediately and asynchronously. On release, scanning restarts at (0,0).
- Wrap coincidence: at (799,524) the next pix_tick wraps both counters and loads flag_q in the same clock.
- CLK_DIV = 1: pix_tick is always high and div_cnt stays 0.
- Minimum flag visibility: a result_in pulse shorter than one frame is visible only if it is high on the frame-boundary tick.

## Structure
- Package vga_timing_pkg holds the default 640x480 constants, the derived H_TOTAL/V_TOTAL and counter widths, and an rgb_t typedef of three COLOR_W fields.
- Sub-module vga_timing_gen holds div_cnt, h_cnt, v_cnt and pix_tick. It exports h_cnt, v_cnt, pix_tick and frame_wrap.
- The top level contains flag_q, the pixel decode and the output registers.
- Planned size: about 180 lines total.

## Test plan
- Reset held 10 clocks, then released → during reset hs = vs = 1 and rgb = 0. The clock after release shows frame_start = 1, active = 1, rgb = F,F,F (border).
- Free-run one line → the vga_hs falling edge is 656*4 clocks after the (0,0) output. Hs stays low 384 clocks. The hs-to-hs period is 3200 clocks. active is high for exactly 2560 clocks per visible line.
- result_in = 1 held before the 2nd frame boundary → pixel (320,240) is F,0,0 in frame 1 and 0,F,0 in frame 2. Pixel (7,240) is F,F,F and pixel (8,240) is 0,F,0.
- result_in toggled 1→0 at line 100 of a green frame → the rest of that frame stays green. The next frame is red.
- Full frame → vga_vs is low only for lines 490–491 (6400 clocks). frame_start pulses are 1,680,000 clocks apart. rgb = 0 whenever active = 0.
- Reset asserted at line 300 → the outputs drop to their reset values the same clock, asynchronously. After release the scan restarts at (0,0) and flag_q = 0 (red frame).
